// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter sharing one memory bus between I-refill and D ports.
// Define MEM_ARB_TIMEOUT_EN to build the ISSUE/WAIT watchdog that aborts hung transactions.
module mem_port_arbiter #(
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic [2:0]  i_trd,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic [2:0]  i_rtrd,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_trd,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [2:0]  d_rtrd,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic        busy,
  output logic        err,
  output logic        err_src,
  output logic [2:0]  err_trd
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e      state_q;
  logic        last_d_q;
  logic        src_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  trd_q;

  logic        idle;
  logic        pick_d;
  logic        done;
  logic        timeout;
  logic [31:0] resp_data;

  if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > 1023) begin : g_bad_timeout
    $error("MEM_TIMEOUT must be in 2..1023");
  end

  assign idle   = (state_q == StIdle);
  // On a tie, last_d_q=1 hands the grant to I.
  assign pick_d = d_req & (~i_req | ~last_d_q);
  assign i_gnt  = idle & i_req & ~pick_d;
  assign d_gnt  = idle & pick_d;
  assign busy   = ~idle;

  assign m_req   = (state_q == StIssue);
  assign m_we    = we_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;

  assign done = ((state_q == StIssue) & m_ack & (we_q | m_rvalid)) |
                ((state_q == StWait) & m_rvalid);
  assign resp_data = we_q ? 32'h0 : m_rdata;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [9:0] cnt_q;

  // Completion in the expiry cycle wins over the abort.
  assign timeout = ((state_q == StIssue) | (state_q == StWait)) &
                   ((cnt_q + 10'd1) == 10'(MEM_TIMEOUT)) & ~done;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
  assign err_src = 1'b0;
  assign err_trd = 3'd0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      last_d_q <= 1'b1;
      src_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      trd_q    <= 3'd0;
      i_rvalid <= 1'b0;
      i_rdata  <= 32'h0;
      i_rtrd   <= 3'd0;
      d_rvalid <= 1'b0;
      d_rdata  <= 32'h0;
      d_rtrd   <= 3'd0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q    <= 10'd0;
      err      <= 1'b0;
      err_src  <= 1'b0;
      err_trd  <= 3'd0;
`endif
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (i_req | d_req) begin
            src_q    <= pick_d;
            last_d_q <= pick_d;
            we_q     <= pick_d & d_wr;
            addr_q   <= pick_d ? d_addr : i_addr;
            wdata_q  <= pick_d ? d_wdata : 32'h0;
            trd_q    <= pick_d ? d_trd : i_trd;
            state_q  <= StIssue;
          end
        end
        StIssue: begin
          if (done)         state_q <= StResp;
          else if (timeout) state_q <= StIdle;
          else if (m_ack)   state_q <= StWait;
        end
        StWait: begin
          if (done)         state_q <= StResp;
          else if (timeout) state_q <= StIdle;
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      if (done) begin
        if (src_q) begin
          d_rvalid <= 1'b1;
          d_rdata  <= resp_data;
          d_rtrd   <= trd_q;
        end else begin
          i_rvalid <= 1'b1;
          i_rdata  <= resp_data;
          i_rtrd   <= trd_q;
        end
      end

`ifdef MEM_ARB_TIMEOUT_EN
      err <= 1'b0;
      if ((state_q == StIssue) | (state_q == StWait)) cnt_q <= cnt_q + 10'd1;
      else                                            cnt_q <= 10'd0;
      if (timeout) begin
        err     <= 1'b1;
        err_src <= src_q;
        err_trd <= trd_q;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; responses are checked by a scoreboard monitor.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic [2:0]  i_trd, i_rtrd;
  logic        d_req, d_wr, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [2:0]  d_trd, d_rtrd;
  logic        m_req, m_we, m_ack, m_rvalid;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        busy, err, err_src;
  logic [2:0]  err_trd;

  typedef struct packed {
    logic        src;
    logic [31:0] data;
    logic [2:0]  trd;
  } resp_t;

  resp_t exp_q[$];
  resp_t mon_e;
  int    checks = 0;
  int    errors = 0;

  mem_port_arbiter #(.MEM_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_trd(i_trd), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rtrd(i_rtrd),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_trd(d_trd),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_rtrd(d_rtrd),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .busy(busy), .err(err), .err_src(err_src), .err_trd(err_trd)
  );

  always #5 clk = ~clk;

  wire [145:0] all_out = {i_gnt, i_rvalid, i_rdata, i_rtrd, d_gnt, d_rvalid, d_rdata, d_rtrd,
                          m_req, m_we, m_addr, m_wdata, busy, err, err_src, err_trd};

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Scoreboard monitor: every response strobe must match the oldest expected entry.
  always @(negedge clk) begin
    if (i_rvalid) begin
      if (exp_q.size() == 0) check("i_rvalid_unexpected", i_rvalid, 0);
      else begin
        mon_e = exp_q.pop_front();
        check("i_resp", {1'b0, i_rdata, i_rtrd}, mon_e);
      end
    end
    if (d_rvalid) begin
      if (exp_q.size() == 0) check("d_rvalid_unexpected", d_rvalid, 0);
      else begin
        mon_e = exp_q.pop_front();
        check("d_resp", {1'b1, d_rdata, d_rtrd}, mon_e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    logic seen_err;
    rst_n = 1'b0;
    i_req = 0; i_addr = 0; i_trd = 0;
    d_req = 0; d_wr = 0; d_addr = 0; d_wdata = 0; d_trd = 0;
    m_ack = 0; m_rvalid = 0; m_rdata = 0;
    cyc(); cyc();
    mid(); check("reset_outputs", all_out, 0);
    cyc(); rst_n = 1'b1;

    // I read alone: gnt cycle 0, m_req cycle 1, rvalid cycle 3.
    cyc(); i_req = 1; i_addr = 32'h40; i_trd = 3;
    mid(); check("rd_gnt", {i_gnt, d_gnt}, 2'b10);
    exp_q.push_back('{1'b0, 32'hDEADBEEF, 3'd3});
    cyc(); i_req = 0; m_ack = 1;
    mid(); check("rd_issue", {m_req, m_we, m_addr, busy}, {1'b1, 1'b0, 32'h40, 1'b1});
    cyc(); m_ack = 0; m_rvalid = 1; m_rdata = 32'hDEADBEEF;
    mid(); check("rd_wait_mreq", m_req, 0);
    cyc(); m_rvalid = 0;
    mid(); check("rd_rvalid_c3", i_rvalid, 1);
    cyc();
    mid(); check("rd_idle", {busy, i_rvalid}, 2'b00);

    // Tie from reset: I, D, I, D; same-cycle ack+rvalid takes the short path.
    cyc(); rst_n = 0;
    cyc(); rst_n = 1; i_req = 1; i_addr = 32'h200; i_trd = 1;
    d_req = 1; d_wr = 0; d_addr = 32'h300; d_trd = 6;
    for (int k = 0; k < 4; k++) begin
      mid();
      check("tie_gnt", {busy, i_gnt, d_gnt}, {1'b0, (k % 2 == 0), (k % 2 == 1)});
      exp_q.push_back('{(k % 2 == 1), 32'hA0000000 + k, (k % 2 == 1) ? 3'd6 : 3'd1});
      cyc(); m_ack = 1; m_rvalid = 1; m_rdata = 32'hA0000000 + k;
      mid();
      check("tie_issue", {i_gnt, d_gnt, m_req, m_addr},
            {2'b00, 1'b1, (k % 2 == 1) ? 32'h300 : 32'h200});
      cyc(); m_ack = 0; m_rvalid = 0;
      if (k == 3) begin i_req = 0; d_req = 0; end
      mid(); check("tie_resp_nognt", {i_gnt, d_gnt, busy}, 3'b001);
      cyc();
    end

    // D write with m_ack delayed 3 cycles.
    d_req = 1; d_wr = 1; d_addr = 32'h100; d_wdata = 32'h12345678; d_trd = 5;
    mid(); check("wr_gnt", {i_gnt, d_gnt}, 2'b01);
    exp_q.push_back('{1'b1, 32'h0, 3'd5});
    for (int j = 0; j < 4; j++) begin
      cyc(); d_req = 0; d_wr = 0; d_wdata = 32'hFFFFFFFF; m_ack = (j == 3);
      mid(); check("wr_hold", {m_req, m_we, m_addr, m_wdata}, {2'b11, 32'h100, 32'h12345678});
    end
    cyc(); m_ack = 0;
    mid(); check("wr_rvalid", {d_rvalid, d_rdata}, {1'b1, 32'h0});
    cyc();

    // Stray m_rvalid in IDLE and in ISSUE before m_ack.
    m_rvalid = 1; m_rdata = 32'hBAD0BAD0;
    mid(); check("stray_idle", {busy, i_rvalid, d_rvalid}, 3'b000);
    cyc(); m_rvalid = 0; i_req = 1; i_addr = 32'h44; i_trd = 2;
    mid(); check("stray_gnt", i_gnt, 1);
    exp_q.push_back('{1'b0, 32'h11111111, 3'd2});
    cyc(); i_req = 0; m_rvalid = 1;
    mid(); check("stray_issue", {m_req, i_rvalid}, 2'b10);
    cyc(); m_rvalid = 0; m_ack = 1;
    cyc(); m_ack = 0; m_rvalid = 1; m_rdata = 32'h11111111;
    cyc(); m_rvalid = 0;
    mid(); check("stray_rvalid", i_rvalid, 1);
    cyc();
    mid(); check("rdata_hold", {i_rvalid, i_rdata, i_rtrd}, {1'b0, 32'h11111111, 3'd2});

    // Reset during WAIT discards the response.
    cyc(); d_req = 1; d_wr = 0; d_addr = 32'h500; d_trd = 4;
    cyc(); d_req = 0; m_ack = 1;
    cyc(); m_ack = 0; rst_n = 0;
    mid(); check("rst_in_wait", {busy, m_req}, 2'b10);
    cyc(); rst_n = 1; m_rvalid = 1; m_rdata = 32'h77777777;
    mid(); check("rst_outputs_0", all_out, 0);
    cyc(); m_rvalid = 0;
    mid(); check("rst_outputs_1", all_out, 0);

`ifdef MEM_ARB_TIMEOUT_EN
    // D read that never completes: err 8 cycles after ISSUE entry.
    cyc(); d_req = 1; d_wr = 0; d_addr = 32'h600; d_trd = 7;
    cyc(); d_req = 0; m_ack = 1;
    mid();
    n = 0;
    seen_err = 0;
    for (int t = 1; t <= 20 && !seen_err; t++) begin
      cyc(); m_ack = 0;
      mid();
      if (err) begin seen_err = 1; n = t; end
    end
    check("to_err_cycle", n, 8);
    check("to_err_fields", {err_src, err_trd, d_rvalid, m_req}, {1'b1, 3'd7, 2'b00});
    cyc();
    mid(); check("to_err_pulse", {err, busy}, 2'b00);
`else
    // No watchdog: a hung read waits indefinitely and still completes.
    cyc(); d_req = 1; d_wr = 0; d_addr = 32'h600; d_trd = 7;
    exp_q.push_back('{1'b1, 32'hCAFEF00D, 3'd7});
    cyc(); d_req = 0; m_ack = 1;
    seen_err = 0;
    for (int t = 0; t < 80; t++) begin
      cyc(); m_ack = 0;
      mid(); if (err) seen_err = 1;
    end
    check("hang_no_err", {seen_err, busy}, 2'b01);
    cyc(); m_rvalid = 1; m_rdata = 32'hCAFEF00D;
    cyc(); m_rvalid = 0;
    mid(); check("hang_rvalid", d_rvalid, 1);
    cyc();
`endif

    // Next request after the long transaction is served normally.
    cyc(); i_req = 1; i_addr = 32'h80; i_trd = 4;
    mid(); check("post_gnt", i_gnt, 1);
    exp_q.push_back('{1'b0, 32'h5A5A5A5A, 3'd4});
    cyc(); i_req = 0; m_ack = 1; m_rvalid = 1; m_rdata = 32'h5A5A5A5A;
    cyc(); m_ack = 0; m_rvalid = 0;
    mid(); check("post_rvalid", i_rvalid, 1);
    cyc(); cyc();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
